capture_buffer: RTL and testbench

Sample-storage and readout stage directly downstream of the trigger node in the on-chip logic analyser. It writes probe samples into an internal RAM under the trigger node's wt_ce/wt_en/wt_addr strobes. On stop_flag it freezes the capture and records the stop address. It then streams the captured window out, oldest sample first, over a valid/ready interface to the JTAG status/readout logic.

---
 rtl/capture_buffer.sv | 255 +++++++++++++++++++++++++
 tb/tb_capture_buffer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// ---------------------------------------------------------------------------
// capture_buffer
//
// Sample storage and readout stage of the on-chip logic analyser. It sits
// directly downstream of the trigger node. Probe samples are written into
// an internal RAM under the trigger node's write strobes. When the trigger
// node signals stop, the capture is frozen and the stop address is kept.
// The captured window is then streamed out, oldest sample first, over a
// valid/ready interface.
//
// Parameters:
//   DATA_W   probe sample width
//   ADDR_W   RAM address width (DEPTH = 2**ADDR_W)
//   DIN_DLY  register stages on trig_din_i that align it with the strobes
//
// Ports:
//   trig_clk_i     sampling clock, rising edge
//   trig_rst_i     asynchronous active-high reset
//   trig_din_i     probe sample bus
//   wt_ce_i        write clock-enable from the trigger node
//   wt_en_i        write enable from the trigger node
//   wt_addr_i      write address; only the low ADDR_W bits are used
//   stop_flag_i    capture-complete flag
//   stop_addr_i    address of the last valid sample (low ADDR_W bits)
//   arm_i          pulse: start a capture (honoured in IDLE only)
//   clear_i        synchronous abort back to IDLE
//   rd_start_i     pulse: start readout (honoured in DONE only)
//   rd_ready_i     consumer ready
//   rd_valid_o     rd_data_o holds a valid beat
//   rd_data_o      sample being read out
//   rd_last_o      marks the final beat
//   state_o        0 IDLE, 1 CAPTURE, 2 DONE, 3 READOUT
//   sample_cnt_o   number of stored samples, saturating at DEPTH
// ---------------------------------------------------------------------------
module capture_buffer #(
    parameter int DATA_W  = 13,
    parameter int ADDR_W  = 9,
    parameter int DIN_DLY = 1
) (
    input  logic              trig_clk_i,
    input  logic              trig_rst_i,
    input  logic [DATA_W-1:0] trig_din_i,
    input  logic              wt_ce_i,
    input  logic              wt_en_i,
    input  logic [15:0]       wt_addr_i,
    input  logic              stop_flag_i,
    input  logic [15:0]       stop_addr_i,
    input  logic              arm_i,
    input  logic              clear_i,
    input  logic              rd_start_i,
    input  logic              rd_ready_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   sample_cnt_o
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     sampleCnt_q;
    logic [ADDR_W-1:0]   stopPtr_q;
    logic [ADDR_W-1:0]   rdPtr_q;
    logic [ADDR_W:0]     remain_q;

    // Readout pipeline: RAM output stage, skid register, output register.
    logic                ramVld_q;
    logic                ramLast_q;
    logic [DATA_W-1:0]   ramData_q;
    logic                skidVld_q;
    logic                skidLast_q;
    logic [DATA_W-1:0]   skidData_q;
    logic                outVld_q;
    logic                outLast_q;
    logic [DATA_W-1:0]   outData_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   dinDly;
    logic                wrStrobe;
    logic                pop;
    logic                issue;
    logic [1:0]          occ;

    // Upper address bits are don't-care; the addresses wrap through the low bits.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{wt_addr_i[15:ADDR_W], stop_addr_i[15:ADDR_W]};

    // Alignment delay on the probe bus so the sample written matches the
    // strobes the trigger node generated for it.
    generate
        if (DIN_DLY == 0) begin : gNoDly
            assign dinDly = trig_din_i;
        end else begin : gDly
            logic [DATA_W-1:0] dly_q [DIN_DLY];

            always_ff @(posedge trig_clk_i or posedge trig_rst_i) begin
                if (trig_rst_i) begin
                    for (int i = 0; i < DIN_DLY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= trig_din_i;
                    for (int i = 1; i < DIN_DLY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign dinDly = dly_q[DIN_DLY-1];
        end
    endgenerate

    // Writes only land while capturing; an abort in the same cycle suppresses
    // the write so the RAM is left exactly as it was.
    assign wrStrobe = (state_q == CAPTURE) && wt_ce_i && wt_en_i && !clear_i;

    // Fetch scheduling. occ counts beats held in the RAM output stage, the
    // skid register and the output register. A new fetch may be issued only
    // if everything in flight plus the new beat still fits in the output and
    // skid registers should the consumer stall from now on. That keeps the
    // stream back-to-back under constant ready and never drops a beat.
    always_comb begin
        pop   = outVld_q && rd_ready_i;
        occ   = 2'(outVld_q) + 2'(skidVld_q) + 2'(ramVld_q);
        issue = 1'b0;
        if (state_q == READOUT && !clear_i && remain_q != '0) begin
            if (occ < 2'd2 || (occ == 2'd2 && pop)) begin
                issue = 1'b1;
            end
        end
    end

    // Sample RAM: synchronous write port and synchronous read port, with no
    // reset so it maps onto block RAM.
    always_ff @(posedge trig_clk_i) begin
        if (wrStrobe) begin
            mem[wt_addr_i[ADDR_W-1:0]] <= dinDly;
        end
        if (issue) begin
            ramData_q <= mem[rdPtr_q];
        end
    end

    // Control FSM, sample counter and readout pipeline registers. An abort
    // flushes the pipeline but deliberately keeps sample_cnt and stop_ptr.
    always_ff @(posedge trig_clk_i or posedge trig_rst_i) begin
        if (trig_rst_i) begin
            state_q     <= IDLE;
            sampleCnt_q <= '0;
            stopPtr_q   <= '0;
            rdPtr_q     <= '0;
            remain_q    <= '0;
            ramVld_q    <= 1'b0;
            ramLast_q   <= 1'b0;
            skidVld_q   <= 1'b0;
            skidLast_q  <= 1'b0;
            skidData_q  <= '0;
            outVld_q    <= 1'b0;
            outLast_q   <= 1'b0;
            outData_q   <= '0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            remain_q  <= '0;
            ramVld_q  <= 1'b0;
            skidVld_q <= 1'b0;
            outVld_q  <= 1'b0;
            outLast_q <= 1'b0;
        end else begin
            if (wrStrobe && sampleCnt_q != DEPTH_CNT) begin
                sampleCnt_q <= sampleCnt_q + CNT_ONE;
            end

            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q     <= CAPTURE;
                        sampleCnt_q <= '0;
                    end
                end
                CAPTURE: begin
                    if (stop_flag_i) begin
                        stopPtr_q <= stop_addr_i[ADDR_W-1:0];
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (rd_start_i) begin
                        if (sampleCnt_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            // Oldest sample sits sample_cnt-1 slots behind
                            // stop_ptr, modulo the RAM depth.
                            state_q  <= READOUT;
                            rdPtr_q  <= stopPtr_q + PTR_ONE - sampleCnt_q[ADDR_W-1:0];
                            remain_q <= sampleCnt_q;
                        end
                    end
                end
                READOUT: begin
                    if (pop && outLast_q) begin
                        state_q <= IDLE;
                    end
                end
            endcase

            if (issue) begin
                rdPtr_q   <= rdPtr_q + PTR_ONE;
                remain_q  <= remain_q - CNT_ONE;
                ramLast_q <= (remain_q == CNT_ONE);
            end
            ramVld_q <= issue;

            // Oldest-first ordering is output, then skid, then RAM stage.
            if (!outVld_q || pop) begin
                if (skidVld_q) begin
                    outVld_q   <= 1'b1;
                    outData_q  <= skidData_q;
                    outLast_q  <= skidLast_q;
                    skidVld_q  <= ramVld_q;
                    skidData_q <= ramData_q;
                    skidLast_q <= ramLast_q;
                end else if (ramVld_q) begin
                    outVld_q  <= 1'b1;
                    outData_q <= ramData_q;
                    outLast_q <= ramLast_q;
                end else begin
                    outVld_q  <= 1'b0;
                    outLast_q <= 1'b0;
                end
            end else if (ramVld_q) begin
                skidVld_q  <= 1'b1;
                skidData_q <= ramData_q;
                skidLast_q <= ramLast_q;
            end
        end
    end

    assign rd_valid_o   = outVld_q;
    assign rd_data_o    = outData_q;
    assign rd_last_o    = outLast_q;
    assign state_o      = state_q;
    assign sample_cnt_o = sampleCnt_q;

endmodule

// File: tb/tb_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_capture_buffer
//
// Directed bench for capture_buffer. Stimulus pushes the expected readout
// beats into a queue; an independent monitor pops and compares every beat
// the DUT hands over, and also watches that stalled beats hold still and
// that the block drops back to IDLE after the final beat.
// ---------------------------------------------------------------------------
module tb_capture_buffer;

    localparam int DATA_W  = 13;
    localparam int ADDR_W  = 9;
    localparam int DIN_DLY = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              wtCe;
    logic              wtEn;
    logic [15:0]       wtAddr;
    logic              stopFlag;
    logic [15:0]       stopAddr;
    logic              arm;
    logic              clear;
    logic              rdStart;
    logic              rdReady;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic              rdLast;
    logic [1:0]        state;
    logic [ADDR_W:0]   sampleCnt;

    int total = 0;
    int bad   = 0;

    // Expected beats, packed as {last, data}.
    logic [DATA_W:0] expQ [$];

    always #5 clk = ~clk;

    capture_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DIN_DLY(DIN_DLY)
    ) dut (
        .trig_clk_i  (clk),
        .trig_rst_i  (rst),
        .trig_din_i  (din),
        .wt_ce_i     (wtCe),
        .wt_en_i     (wtEn),
        .wt_addr_i   (wtAddr),
        .stop_flag_i (stopFlag),
        .stop_addr_i (stopAddr),
        .arm_i       (arm),
        .clear_i     (clear),
        .rd_start_i  (rdStart),
        .rd_ready_i  (rdReady),
        .rd_valid_o  (rdValid),
        .rd_data_o   (rdData),
        .rd_last_o   (rdLast),
        .state_o     (state),
        .sample_cnt_o(sampleCnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n samples. With one stage of input delay, strobe cycle i writes
    // the sample presented in cycle i-1. The optional stop pulse shares the
    // cycle of the final strobe.
    task automatic applyStimulus(input int n, input int addrBase, input int dataBase,
                                 input logic ce, input logic en,
                                 input logic stopOnLast, input int stopAt);
        for (int i = 0; i <= n; i++) begin
            din      = (i < n) ? DATA_W'(dataBase + i) : '0;
            wtCe     = (i > 0) ? ce : 1'b0;
            wtEn     = (i > 0) ? en : 1'b0;
            wtAddr   = 16'(addrBase + i - 1);
            stopFlag = stopOnLast && (i == n);
            stopAddr = 16'(stopAt);
            tick();
        end
        din      = '0;
        wtCe     = 1'b0;
        wtEn     = 1'b0;
        stopFlag = 1'b0;
    endtask

    task automatic pulseArm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic startRead();
        rdStart = 1'b1;
        tick();
        rdStart = 1'b0;
    endtask

    task automatic pushBeats(input int firstVal, input int count);
        for (int k = 0; k < count; k++) begin
            expQ.push_back({(k == count - 1), DATA_W'(firstVal + k)});
        end
    endtask

    task automatic drainQueue(input string name, input int maxCycles, input logic toggle);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            rdReady = toggle ? ~rdReady : 1'b1;
            tick();
            n++;
        end
        checkOutput({name, "_drained"}, expQ.size(), 0);
        expQ.delete();
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    initial begin
        logic              prevStall = 1'b0;
        logic [DATA_W-1:0] prevData  = '0;
        logic              prevLast  = 1'b0;
        logic              chkIdle   = 1'b0;
        logic [DATA_W:0]   expBeat;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall = 1'b0;
                chkIdle   = 1'b0;
            end else begin
                if (chkIdle) begin
                    chkIdle = 1'b0;
                    checkOutput("after_last_valid", rdValid, 0);
                    checkOutput("after_last_state", state, 0);
                end
                if (prevStall) begin
                    checkOutput("stall_valid", rdValid, 1);
                    checkOutput("stall_data", rdData, prevData);
                    checkOutput("stall_last", rdLast, prevLast);
                end
                prevStall = rdValid && !rdReady && !clear;
                prevData  = rdData;
                prevLast  = rdLast;
                if (rdValid && rdReady && !clear) begin
                    if (expQ.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat", rdData);
                    end else begin
                        expBeat = expQ.pop_front();
                        checkOutput("beat_data", rdData, expBeat[DATA_W-1:0]);
                        checkOutput("beat_last", rdLast, expBeat[DATA_W]);
                        if (expBeat[DATA_W]) begin
                            chkIdle = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        din      = '0;
        wtCe     = 1'b0;
        wtEn     = 1'b0;
        wtAddr   = '0;
        stopFlag = 1'b0;
        stopAddr = '0;
        arm      = 1'b0;
        clear    = 1'b0;
        rdStart  = 1'b0;
        rdReady  = 1'b1;

        // Reset state
        repeat (3) tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_valid", rdValid, 0);
        checkOutput("rst_last", rdLast, 0);
        checkOutput("rst_data", rdData, 0);
        checkOutput("rst_cnt", sampleCnt, 0);
        rst = 1'b0;
        tick();

        // 1: basic capture and readout, back-to-back beats
        $display("[TB] basic capture");
        pulseArm();
        checkOutput("t1_state_capture", state, 1);
        applyStimulus(5, 0, 'h10, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 4);
        checkOutput("t1_state_done", state, 2);
        checkOutput("t1_cnt", sampleCnt, 5);
        pushBeats('h10, 5);
        rdReady = 1'b1;
        startRead();
        checkOutput("t1_valid_c0", rdValid, 0);
        tick();
        checkOutput("t1_valid_c1", rdValid, 0);
        tick();
        checkOutput("t1_valid_c2", rdValid, 1);
        drainQueue("t1", 5, 1'b0);
        repeat (2) tick();

        // 2: wrap-around with stop in the same cycle as the final write
        $display("[TB] wrap-around");
        pulseArm();
        applyStimulus(600, 0, 0, 1'b1, 1'b1, 1'b1, 599);
        checkOutput("t2_state_done", state, 2);
        checkOutput("t2_cnt", sampleCnt, 512);
        pushBeats(88, 512);
        startRead();
        drainQueue("t2", 514, 1'b0);
        repeat (2) tick();

        // 3: backpressure with ready toggling
        $display("[TB] backpressure");
        pulseArm();
        applyStimulus(5, 0, 'h10, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 4);
        pushBeats('h10, 5);
        rdReady = 1'b1;
        startRead();
        drainQueue("t3", 40, 1'b1);
        rdReady = 1'b1;
        repeat (2) tick();
        checkOutput("t3_state_idle", state, 0);

        // 4: gating of writes
        $display("[TB] write gating");
        applyStimulus(2, 0, 'h1FF0, 1'b1, 1'b1, 1'b0, 0);
        checkOutput("t4_idle_cnt", sampleCnt, 5);
        pulseArm();
        applyStimulus(3, 0, 'h20, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(2, 0, 'h1F00, 1'b0, 1'b1, 1'b0, 0);
        applyStimulus(2, 1, 'h1E00, 1'b1, 1'b0, 1'b0, 0);
        checkOutput("t4_gated_cnt", sampleCnt, 3);
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 2);
        pulseArm();
        applyStimulus(2, 0, 'h1D00, 1'b1, 1'b1, 1'b0, 0);
        checkOutput("t4_done_cnt", sampleCnt, 3);
        checkOutput("t4_done_state", state, 2);
        pushBeats('h20, 3);
        startRead();
        drainQueue("t4", 10, 1'b0);
        repeat (2) tick();

        // 5a: clear after two beats
        $display("[TB] abort");
        pulseArm();
        applyStimulus(5, 0, 'h10, 1'b1, 1'b1, 1'b0, 0);
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 4);
        pushBeats('h10, 2);
        expQ[1][DATA_W] = 1'b0;
        startRead();
        drainQueue("t5a", 6, 1'b0);
        clear   = 1'b1;
        rdReady = 1'b0;
        tick();
        clear = 1'b0;
        checkOutput("t5a_valid", rdValid, 0);
        checkOutput("t5a_last", rdLast, 0);
        checkOutput("t5a_state", state, 0);
        checkOutput("t5a_cnt", sampleCnt, 5);
        rdReady = 1'b1;
        repeat (2) tick();

        // 5b: asynchronous reset mid-capture
        $display("[TB] async reset");
        pulseArm();
        applyStimulus(3, 0, 'h30, 1'b1, 1'b1, 1'b0, 0);
        checkOutput("t5b_pre_cnt", sampleCnt, 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5b_state", state, 0);
        checkOutput("t5b_valid", rdValid, 0);
        checkOutput("t5b_cnt", sampleCnt, 0);
        #2 rst = 1'b0;
        tick();

        // 6: empty capture
        $display("[TB] empty capture");
        pulseArm();
        applyStimulus(0, 0, 0, 1'b0, 1'b0, 1'b1, 7);
        checkOutput("t6_cnt", sampleCnt, 0);
        checkOutput("t6_state_done", state, 2);
        startRead();
        checkOutput("t6_state_idle", state, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6_no_valid", rdValid, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
